// File: rtl/scrypt_pkg.sv
// scrypt_pkg: shared types and widths for the scrypt front-end PBKDF2 sequencer
package scrypt_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_STORE,
      S_FINISH
   } state_e;

   localparam int HDR_BITS      = 640;
   localparam int HASH_BITS     = 256;
   localparam int HMAC_IN_BITS  = 1312;
   localparam int IDX_BITS      = 32;
   localparam int PBKDF2_BLOCKS = 4;

endpackage

// File: rtl/pbkdf2_sha256_seq.sv
// pbkdf2_sha256_seq: PBKDF2-HMAC-SHA256 first pass (NUM_BLOCKS HMAC calls); PBKDF2_SHA256_TIMEOUT_EN adds a per-call watchdog
module pbkdf2_sha256_seq
   import scrypt_pkg::*;
#(
   parameter int NUM_BLOCKS     = PBKDF2_BLOCKS,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [HDR_BITS-1:0]             header_in,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   output logic [HASH_BITS*NUM_BLOCKS-1:0] b_out,
   output logic [HMAC_IN_BITS-1:0]         hmac_data,
   output logic                            hmac_enable,
   input  logic [HASH_BITS-1:0]            hmac_hash,
   input  logic                            hmac_done,
   output logic                            error
);

   state_e                          state_q, state_d;
   logic [HDR_BITS-1:0]             hdr_q, hdr_d;
   logic [IDX_BITS-1:0]             idx_q, idx_d;
   logic [HASH_BITS*NUM_BLOCKS-1:0] b_q, b_d;
`ifdef PBKDF2_SHA256_TIMEOUT_EN
   logic [12:0]                     cnt_q, cnt_d;
   logic                            err_q, err_d;
`endif

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 13-bit watchdog counter");
   end

   // Sequencer: latch header, launch each HMAC call, drop its result into the matching slot
   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      idx_d   = idx_q;
      b_d     = b_q;
`ifdef PBKDF2_SHA256_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               hdr_d   = header_in;
               idx_d   = IDX_BITS'(1);
               state_d = S_LAUNCH;
`ifdef PBKDF2_SHA256_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT;
`ifdef PBKDF2_SHA256_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (hmac_done) begin
               for (int k = 0; k < NUM_BLOCKS; k++)
                  if (idx_q == IDX_BITS'(k + 1)) b_d[HASH_BITS*(NUM_BLOCKS-1-k) +: HASH_BITS] = hmac_hash;
               state_d = S_STORE;
            end
`ifdef PBKDF2_SHA256_TIMEOUT_EN
            else if (cnt_q == 13'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
            else cnt_d = cnt_q + 13'd1;
`endif
         end
         S_STORE: begin
            if (idx_q == IDX_BITS'(NUM_BLOCKS)) state_d = S_FINISH;
            else begin
               idx_d   = idx_q + IDX_BITS'(1);
               state_d = S_LAUNCH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath and state registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hdr_q   <= '0;
         idx_q   <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         idx_q   <= idx_d;
         b_q     <= b_d;
      end
   end

`ifdef PBKDF2_SHA256_TIMEOUT_EN
   // Watchdog counter and sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   assign busy        = state_q inside {S_LAUNCH, S_WAIT, S_STORE};
   assign done        = state_q == S_FINISH;
   assign hmac_enable = state_q == S_LAUNCH;
   assign hmac_data   = {hdr_q, hdr_q, idx_q};
   assign b_out       = b_q;

endmodule
